// File: rtl/rt_ibex_window_ctrl.sv
// Interrupt-nesting controller placed in front of the register-window register file.
// An interrupt entry saves mcause/mepc into the window aux store and advances the window.
// An mret retreats the window and returns the saved mcause/mepc to the CSR unit.
// Once every window is in use, further nesting falls back to software stacking,
// and a saturating overflow counter tracks how deep that software nesting is.
//
// Handshake: entry_req_i and mret_req_i are level requests. Each one stays high until its
// ack pulse (entry_ack_o or mret_ack_o, one cycle each). A request is only sampled in IDLE,
// and entry takes priority over mret. A request still high during the ack cycle is taken
// as a new request on the next IDLE cycle.
module rt_ibex_window_ctrl #(
  parameter int unsigned NumWindows  = 4,
  parameter int unsigned OvfCntWidth = 4,
  localparam int unsigned DepthW     = (NumWindows > 1) ? $clog2(NumWindows) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   entry_req_i,
  input  logic                   mret_req_i,
  input  logic [31:0]            mcause_i,
  input  logic [31:0]            mepc_i,
  output logic                   entry_ack_o,
  output logic                   entry_hw_o,
  output logic                   mret_ack_o,
  output logic                   mret_hw_o,
  output logic [31:0]            mcause_o,
  output logic [31:0]            mepc_o,
  output logic                   busy_o,
  output logic [DepthW-1:0]      depth_o,
  output logic [OvfCntWidth-1:0] ovf_cnt_o,
  output logic                   err_o,
  output logic                   increment_ptr_o,
  output logic                   decrement_ptr_o,
  output logic                   save_csr_o,
  output logic [31:0]            mcause_save_o,
  output logic [31:0]            mepc_save_o,
  input  logic                   window_full_i,
  input  logic [31:0]            mcause_rf_i,
  input  logic [31:0]            mepc_rf_i,
  output logic [2:0]             state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    DEC     = 3'd2,
    RESTORE = 3'd3,
    SW_RET  = 3'd4
  } state_e;

  localparam logic [DepthW-1:0]      MaxDepth = DepthW'(NumWindows - 1);
  localparam logic [OvfCntWidth-1:0] OvfMax   = {OvfCntWidth{1'b1}};

  state_e                 state_q, state_d;
  logic [DepthW-1:0]      depth_q, depth_d;
  logic [OvfCntWidth-1:0] ovf_q, ovf_d;
  logic [31:0]            mcause_save_q, mepc_save_q;
  logic [31:0]            mcause_ret_q, mepc_ret_q;
  logic                   capture;
  logic                   at_max;

  assign at_max = (depth_q == MaxDepth);

  // State, depth and software-nesting counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      depth_q <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
    end
  end

  // Capture mcause/mepc when an entry is accepted, so the regfile sees stable save data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcause_save_q <= '0;
      mepc_save_q   <= '0;
    end else if (capture) begin
      mcause_save_q <= mcause_i;
      mepc_save_q   <= mepc_i;
    end
  end

  // Keep the last restored values, so mcause_o/mepc_o hold between acks
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcause_ret_q <= '0;
      mepc_ret_q   <= '0;
    end else if (state_q == RESTORE) begin
      mcause_ret_q <= mcause_rf_i;
      mepc_ret_q   <= mepc_rf_i;
    end
  end

  // Next-state, counter updates and per-state strobes
  always_comb begin
    state_d         = state_q;
    depth_d         = depth_q;
    ovf_d           = ovf_q;
    capture         = 1'b0;
    entry_ack_o     = 1'b0;
    entry_hw_o      = 1'b0;
    mret_ack_o      = 1'b0;
    mret_hw_o       = 1'b0;
    increment_ptr_o = 1'b0;
    decrement_ptr_o = 1'b0;
    save_csr_o      = 1'b0;
    // The regfile's full flag must always agree with our own view of depth
    err_o           = (window_full_i != at_max);

    case (state_q)
      IDLE: begin
        if (entry_req_i) begin
          capture = 1'b1;
          state_d = ENTRY;
        end else if (mret_req_i) begin
          if (ovf_q != '0)       state_d = SW_RET;
          else if (depth_q != '0) state_d = DEC;
          else                    state_d = SW_RET;  // underflow, flagged in SW_RET
        end
      end
      ENTRY: begin
        entry_ack_o = 1'b1;
        state_d     = IDLE;
        if (!at_max) begin
          // Regfile writes aux at the old pointer, then advances the pointer
          save_csr_o      = 1'b1;
          increment_ptr_o = 1'b1;
          entry_hw_o      = 1'b1;
          depth_d         = depth_q + DepthW'(1);
        end else if (ovf_q == OvfMax) begin
          err_o = 1'b1;
        end else begin
          ovf_d = ovf_q + OvfCntWidth'(1);
        end
      end
      DEC: begin
        decrement_ptr_o = 1'b1;
        depth_d         = depth_q - DepthW'(1);
        state_d         = RESTORE;
      end
      RESTORE: begin
        mret_ack_o = 1'b1;
        mret_hw_o  = 1'b1;
        state_d    = IDLE;
      end
      SW_RET: begin
        mret_ack_o = 1'b1;
        state_d    = IDLE;
        // ovf == 0 here only happens on the underflow path, because depth > 0 goes through DEC
        if (ovf_q != '0) ovf_d = ovf_q - OvfCntWidth'(1);
        else             err_o = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mcause_o      = (state_q == RESTORE) ? mcause_rf_i : mcause_ret_q;
  assign mepc_o        = (state_q == RESTORE) ? mepc_rf_i   : mepc_ret_q;
  assign mcause_save_o = mcause_save_q;
  assign mepc_save_o   = mepc_save_q;
  assign busy_o        = (state_q != IDLE);
  assign depth_o       = depth_q;
  assign ovf_cnt_o     = ovf_q;
  assign state_o       = state_q;

endmodule
